soc_bus_fabric: RTL and testbench
=================================

// Module: soc_bus_fabric
// PURPOSE
//  Parametrised address-decode and response fabric between the picorv32 native memory bus and NUM_SLAVES peripherals.
//  Replaces hand-written per-peripheral select/ready/rdata muxing in the SoC top.
//  Adds three things: a registered decode stage, a per-access timeout watchdog, and a bus-error response with an IRQ pulse and capture.
// PARAMETERS
//  NUM_SLAVES      4                       slave port count (1..16)
//  SLAVE_BASE      {32'h0400_0000,32'h0200_0008,32'h0200_0004,32'h0000_0000}  packed 32*N base addresses; slave i = bits [32i+31:32i]
//  SLAVE_MASK      {32'hFF00_0000,32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FC00}  packed 32*N; slave i hits when (m_addr & MASK_i)==BASE_i
//  TIMEOUT_CYCLES  255                     max wait for s_ready; 0 disables timeout
//  ERR_RDATA       32'hDEAD_BEEF           m_rdata returned on decode miss or timeout
// PORTS
//  clk         in   1      system clock
//  resetn      in   1      asynchronous active-low reset
//  m_valid     in   1      master request (picorv32 mem_valid)
//  m_addr      in   32     master address
//  m_wstrb     in   4      write strobes; 0 = read (used only for error capture)
//  m_ready     out  1      access complete, one-cycle pulse
//  m_rdata     out  32     read data, valid while m_ready=1
//  s_valid     out  N      one-hot slave request; addr/wdata/wstrb fan out from master outside this block
//  s_ready     in   N      slave completion
//  s_rdata     in   32*N   slave read data, slave i = bits [32i+31:32i]
//  err_irq     out  1      one-cycle pulse per bus error (maps to irq[3])
//  err_addr    out  32     address of last errored access
//  err_write   out  1      1 if last errored access was a write
//  err_count   out  8      saturating bus-error count
// BEHAVIOUR
//  Reset:
//   - Async, all state cleared. FSM enters IDLE.
//   - s_valid=0, m_ready=0, m_rdata=0, err_irq=0, err_addr=0, err_write=0, err_count=0.
//   - Reset asserted mid-access aborts that access immediately; no m_ready is issued.
//  FSM states: IDLE, DECODE, ACTIVE, ERROR, DONE.
//   - IDLE:
//     - m_valid=1 -> DECODE.
//   - DECODE (1 cycle):
//     - Match all slaves in parallel. Lowest index wins when more than one slave matches.
//     - On a hit: latch sel, clear wait counter -> ACTIVE.
//     - On no hit -> ERROR.
//   - ACTIVE:
//     - s_valid[sel]=1; all other s_valid bits are 0.
//     - m_ready = s_ready[sel] (combinational). m_rdata = s_rdata[sel] while m_ready=1.
//     - On s_ready[sel] -> DONE.
//     - If the wait counter reaches TIMEOUT_CYCLES with no s_ready: drop s_valid -> ERROR.
//     - If s_ready and timeout occur in the same cycle, s_ready wins; this is a normal completion.
//     - If m_valid falls while in ACTIVE: drop s_valid -> IDLE, no m_ready, no error.
//   - ERROR (1 cycle, all outputs registered):
//     - m_ready=1, m_rdata=ERR_RDATA, err_irq=1.
//     - err_addr<=m_addr, err_write<=|m_wstrb.
//     - err_count<=err_count+1, saturating at 8'hFF.
//     - Next state -> DONE.
//   - DONE (1 cycle):
//     - m_ready=0, s_valid=0. Absorbs the cycle in which the master drops or re-presents m_valid.
//     - Next state -> IDLE.
//  Timing and rules:
//   - Latency: m_valid rising edge -> s_valid is 2 cycles (IDLE->DECODE->ACTIVE).
//   - A zero-wait slave completes 2 cycles after m_valid.
//   - m_addr, m_wstrb and m_wdata are held stable by the master until m_ready.
//   - The fabric does not register address or data.
//   - Wait counter is $clog2(TIMEOUT_CYCLES+1) bits. It increments once per cycle in ACTIVE and never wraps.
//   - s_ready from unselected slaves is ignored.
//   - m_ready is never asserted outside ACTIVE or ERROR, and never for 2 consecutive cycles.
// TESTING
//  1. Read 0x0000_0010; slave0 gives s_ready on its first ACTIVE cycle with rdata 0x1234_5678
//     -> s_valid=4'b0001 at cycle 2, m_ready at cycle 2, m_rdata=0x1234_5678.
//  2. Write 0x0400_0020, wstrb=4'hF; slave3 gives s_ready after 5 cycles
//     -> s_valid=4'b1000 held for 6 cycles, m_ready once, err_count stays 0.
//  3. Read 0x0300_0000 (no match)
//     -> m_ready at cycle 2 with m_rdata=0xDEAD_BEEF, err_irq pulse, err_addr=0x0300_0000, err_write=0.
//  4. TIMEOUT_CYCLES=8; slave1 never gives s_ready
//     -> s_valid drops after 8 ACTIVE cycles, m_rdata=0xDEAD_BEEF, err_irq, err_count=1.
//     Repeat with s_ready on the 8th cycle -> normal completion, no error.
//  5. Drive 300 decode misses back to back -> err_count saturates at 0xFF.
//  6. resetn low during ACTIVE -> s_valid=0 and m_ready=0 immediately.
//     After release, a fresh access completes normally.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// Address-decode and response fabric between the picorv32 native memory bus and NUM_SLAVES peripherals.
// Registered decode, per-access timeout watchdog, and bus-error response with IRQ pulse and capture.
module soc_bus_fabric #(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h0400_0000, 32'h0200_0008,
                                                           32'h0200_0004, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {32'hFF00_0000, 32'hFFFF_FFFF,
                                                           32'hFFFF_FFFF, 32'hFFFF_FC00},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      m_valid,
    input  logic [31:0]               m_addr,
    input  logic [3:0]                m_wstrb,
    output logic                      m_ready,
    output logic [31:0]               m_rdata,
    output logic [NUM_SLAVES-1:0]     s_valid,
    input  logic [NUM_SLAVES-1:0]     s_ready,
    input  logic [32*NUM_SLAVES-1:0]  s_rdata,
    output logic                      err_irq,
    output logic [31:0]               err_addr,
    output logic                      err_write,
    output logic [7:0]                err_count
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACTIVE,
        ST_ERROR,
        ST_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SEL_W-1:0]        sel_p1;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    hit;
    logic [SEL_W-1:0]        hit_sel;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    timeout_hit;

    // Decode stage: all windows compared in parallel, descending scan so the lowest index wins
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_sel = SEL_W'(i);
            end
        end
    end

    // Active stage: only the latched slave's ready/rdata are visible to the master
    always_comb begin
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_p1 == SEL_W'(i)) begin
                sel_ready     = s_ready[i];
                sel_rdata     = s_rdata[32*i +: 32];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    // err_irq is high exactly during the ERROR cycle, so it doubles as the registered error response
    always_comb begin
        state_d = state_q;
        s_valid = '0;
        m_ready = err_irq;
        m_rdata = err_irq ? ERR_RDATA : 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = hit ? ST_ACTIVE : ST_ERROR;
            end
            ST_ACTIVE: begin
                if (!m_valid) begin
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    s_valid = sel_onehot;
                    m_ready = 1'b1;
                    m_rdata = sel_rdata;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    s_valid = sel_onehot;
                    state_d = ST_ERROR;
                end else begin
                    s_valid = sel_onehot;
                end
            end
            ST_ERROR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            sel_p1    <= '0;
            wait_cnt  <= '0;
            err_irq   <= 1'b0;
            err_addr  <= 32'h0;
            err_write <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state_q <= state_d;
            err_irq <= (state_d == ST_ERROR);
            if (state_q == ST_DECODE) begin
                sel_p1   <= hit_sel;
                wait_cnt <= '0;
            end else if ((state_q == ST_ACTIVE) && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_d == ST_ERROR) begin
                err_addr  <= m_addr;
                err_write <= |m_wstrb;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: decode, wait states, decode miss, timeout, saturation, reset abort.
module tb_soc_bus_fabric;

    logic         clk = 1'b0;
    logic         resetn;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic [3:0]   m_wstrb;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_irq;
    logic [31:0]  err_addr;
    logic         err_write;
    logic [7:0]   err_count;

    int vec_cnt = 0;
    int miscmp  = 0;

    soc_bus_fabric #(
        .NUM_SLAVES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_write (err_write),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        resetn  = 1'b0;
        m_valid = 1'b0;
        s_ready = 4'b0000;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        resetn  = 1'b1;
        m_valid = 1'b0;
        m_addr  = 32'h0;
        m_wstrb = 4'h0;
        s_ready = 4'b0000;
        s_rdata = '0;
        #1 resetn = 1'b0;
        #1;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL rst_s_valid got %b exp 0000", s_valid); end
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL rst_m_ready got %b exp 0", m_ready); end
        vec_cnt++; if (m_rdata !== 32'h0) begin miscmp++; $display("FAIL rst_m_rdata got %h exp 0", m_rdata); end
        vec_cnt++; if (err_irq !== 1'b0) begin miscmp++; $display("FAIL rst_err_irq got %b exp 0", err_irq); end
        vec_cnt++; if (err_addr !== 32'h0) begin miscmp++; $display("FAIL rst_err_addr got %h exp 0", err_addr); end
        vec_cnt++; if (err_write !== 1'b0) begin miscmp++; $display("FAIL rst_err_write got %b exp 0", err_write); end
        vec_cnt++; if (err_count !== 8'h00) begin miscmp++; $display("FAIL rst_err_count got %h exp 00", err_count); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_wait;
        m_addr  = 32'h0000_0010;
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        s_rdata = '0;
        s_rdata[31:0] = 32'h1234_5678;
        #1;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL rd0_c0_s_valid got %b exp 0000", s_valid); end
        tick(); #1;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL rd0_c1_s_valid got %b exp 0000", s_valid); end
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL rd0_c1_m_ready got %b exp 0", m_ready); end
        tick();
        s_ready = 4'b0001;
        #1;
        vec_cnt++; if (s_valid !== 4'b0001) begin miscmp++; $display("FAIL rd0_c2_s_valid got %b exp 0001", s_valid); end
        vec_cnt++; if (m_ready !== 1'b1) begin miscmp++; $display("FAIL rd0_c2_m_ready got %b exp 1", m_ready); end
        vec_cnt++; if (m_rdata !== 32'h1234_5678) begin miscmp++; $display("FAIL rd0_c2_m_rdata got %h exp 12345678", m_rdata); end
        tick();
        m_valid = 1'b0;
        s_ready = 4'b0000;
        #1;
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL rd0_done_m_ready got %b exp 0", m_ready); end
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL rd0_done_s_valid got %b exp 0000", s_valid); end
        tick();
    endtask

    task automatic test_write_wait;
        logic exp_r;
        int   pulses = 0;
        m_addr  = 32'h0400_0020;
        m_wstrb = 4'hF;
        m_valid = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            // unselected slave0 asserts ready while slave3 is still busy
            s_ready = (k == 5) ? 4'b1000 : 4'b0001;
            exp_r   = (k == 5);
            #1;
            if (m_ready) pulses++;
            vec_cnt++; if (s_valid !== 4'b1000) begin miscmp++; $display("FAIL wr_s_valid k=%0d got %b exp 1000", k, s_valid); end
            vec_cnt++; if (m_ready !== exp_r) begin miscmp++; $display("FAIL wr_m_ready k=%0d got %b exp %b", k, m_ready, exp_r); end
        end
        tick();
        m_valid = 1'b0;
        s_ready = 4'b0000;
        #1;
        if (m_ready) pulses++;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL wr_done_s_valid got %b exp 0000", s_valid); end
        vec_cnt++; if (pulses !== 1) begin miscmp++; $display("FAIL wr_ready_pulses got %0d exp 1", pulses); end
        vec_cnt++; if (err_count !== 8'h00) begin miscmp++; $display("FAIL wr_err_count got %h exp 00", err_count); end
        vec_cnt++; if (err_irq !== 1'b0) begin miscmp++; $display("FAIL wr_err_irq got %b exp 0", err_irq); end
        tick();
    endtask

    task automatic test_decode_miss;
        m_addr  = 32'h0300_0000;
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        tick(); #1;
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL miss_c1_m_ready got %b exp 0", m_ready); end
        tick(); #1;
        vec_cnt++; if (m_ready !== 1'b1) begin miscmp++; $display("FAIL miss_c2_m_ready got %b exp 1", m_ready); end
        vec_cnt++; if (m_rdata !== 32'hDEAD_BEEF) begin miscmp++; $display("FAIL miss_m_rdata got %h exp deadbeef", m_rdata); end
        vec_cnt++; if (err_irq !== 1'b1) begin miscmp++; $display("FAIL miss_err_irq got %b exp 1", err_irq); end
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL miss_s_valid got %b exp 0000", s_valid); end
        tick();
        m_valid = 1'b0;
        #1;
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL miss_done_m_ready got %b exp 0", m_ready); end
        vec_cnt++; if (err_irq !== 1'b0) begin miscmp++; $display("FAIL miss_done_err_irq got %b exp 0", err_irq); end
        vec_cnt++; if (err_addr !== 32'h0300_0000) begin miscmp++; $display("FAIL miss_err_addr got %h exp 03000000", err_addr); end
        vec_cnt++; if (err_write !== 1'b0) begin miscmp++; $display("FAIL miss_err_write got %b exp 0", err_write); end
        vec_cnt++; if (err_count !== 8'h01) begin miscmp++; $display("FAIL miss_err_count got %h exp 01", err_count); end
        tick();
        // first address past slave0's 1 KiB window
        m_addr  = 32'h0000_0400;
        m_valid = 1'b1;
        tick(); tick(); #1;
        vec_cnt++; if (m_rdata !== 32'hDEAD_BEEF) begin miscmp++; $display("FAIL edge_miss_m_rdata got %h exp deadbeef", m_rdata); end
        vec_cnt++; if (err_count !== 8'h02) begin miscmp++; $display("FAIL edge_miss_err_count got %h exp 02", err_count); end
        tick();
        m_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        logic exp_r;
        do_reset();
        m_addr  = 32'h0200_0004;
        m_wstrb = 4'h3;
        m_valid = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            vec_cnt++; if (s_valid !== 4'b0010) begin miscmp++; $display("FAIL to_s_valid k=%0d got %b exp 0010", k, s_valid); end
            vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL to_m_ready k=%0d got %b exp 0", k, m_ready); end
        end
        tick(); #1;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL to_err_s_valid got %b exp 0000", s_valid); end
        vec_cnt++; if (m_ready !== 1'b1) begin miscmp++; $display("FAIL to_err_m_ready got %b exp 1", m_ready); end
        vec_cnt++; if (m_rdata !== 32'hDEAD_BEEF) begin miscmp++; $display("FAIL to_err_m_rdata got %h exp deadbeef", m_rdata); end
        vec_cnt++; if (err_irq !== 1'b1) begin miscmp++; $display("FAIL to_err_irq got %b exp 1", err_irq); end
        vec_cnt++; if (err_count !== 8'h01) begin miscmp++; $display("FAIL to_err_count got %h exp 01", err_count); end
        vec_cnt++; if (err_write !== 1'b1) begin miscmp++; $display("FAIL to_err_write got %b exp 1", err_write); end
        vec_cnt++; if (err_addr !== 32'h0200_0004) begin miscmp++; $display("FAIL to_err_addr got %h exp 02000004", err_addr); end
        tick();
        m_valid = 1'b0;
        tick();
        // ready arriving on the last allowed cycle beats the timeout
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        s_rdata[63:32] = 32'hCAFE_0001;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            s_ready = (k == 7) ? 4'b0010 : 4'b0000;
            exp_r   = (k == 7);
            #1;
            vec_cnt++; if (s_valid !== 4'b0010) begin miscmp++; $display("FAIL to8_s_valid k=%0d got %b exp 0010", k, s_valid); end
            vec_cnt++; if (m_ready !== exp_r) begin miscmp++; $display("FAIL to8_m_ready k=%0d got %b exp %b", k, m_ready, exp_r); end
        end
        vec_cnt++; if (m_rdata !== 32'hCAFE_0001) begin miscmp++; $display("FAIL to8_m_rdata got %h exp cafe0001", m_rdata); end
        tick();
        m_valid = 1'b0;
        s_ready = 4'b0000;
        #1;
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL to8_done_m_ready got %b exp 0", m_ready); end
        vec_cnt++; if (err_irq !== 1'b0) begin miscmp++; $display("FAIL to8_err_irq got %b exp 0", err_irq); end
        vec_cnt++; if (err_count !== 8'h01) begin miscmp++; $display("FAIL to8_err_count got %h exp 01", err_count); end
        tick();
    endtask

    task automatic test_err_saturation;
        int pulses = 0;
        do_reset();
        m_addr  = 32'h0300_0000;
        m_wstrb = 4'h0;
        for (int n = 1; n <= 300; n++) begin
            m_valid = 1'b1;
            tick(); tick(); #1;
            if (m_ready && err_irq) pulses++;
            tick();
            m_valid = 1'b0;
            tick();
            if (n == 254) begin
                vec_cnt++; if (err_count !== 8'hFE) begin miscmp++; $display("FAIL sat_254 got %h exp fe", err_count); end
            end
            if (n == 255) begin
                vec_cnt++; if (err_count !== 8'hFF) begin miscmp++; $display("FAIL sat_255 got %h exp ff", err_count); end
            end
        end
        vec_cnt++; if (err_count !== 8'hFF) begin miscmp++; $display("FAIL sat_300 got %h exp ff", err_count); end
        vec_cnt++; if (pulses !== 300) begin miscmp++; $display("FAIL sat_err_pulses got %0d exp 300", pulses); end
    endtask

    task automatic test_reset_abort;
        m_addr  = 32'h0200_0008;
        m_wstrb = 4'h0;
        m_valid = 1'b1;
        tick(); tick(); #1;
        vec_cnt++; if (s_valid !== 4'b0100) begin miscmp++; $display("FAIL abort_active_s_valid got %b exp 0100", s_valid); end
        s_ready = 4'b0100;
        resetn  = 1'b0;
        #1;
        vec_cnt++; if (s_valid !== 4'b0000) begin miscmp++; $display("FAIL abort_s_valid got %b exp 0000", s_valid); end
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL abort_m_ready got %b exp 0", m_ready); end
        vec_cnt++; if (err_count !== 8'h00) begin miscmp++; $display("FAIL abort_err_count got %h exp 00", err_count); end
        m_valid = 1'b0;
        s_ready = 4'b0000;
        tick();
        resetn = 1'b1;
        tick();
        m_addr  = 32'h0000_03FC;
        m_valid = 1'b1;
        s_rdata[31:0] = 32'hA5A5_0001;
        tick(); tick();
        s_ready = 4'b0001;
        #1;
        vec_cnt++; if (s_valid !== 4'b0001) begin miscmp++; $display("FAIL fresh_s_valid got %b exp 0001", s_valid); end
        vec_cnt++; if (m_ready !== 1'b1) begin miscmp++; $display("FAIL fresh_m_ready got %b exp 1", m_ready); end
        vec_cnt++; if (m_rdata !== 32'hA5A5_0001) begin miscmp++; $display("FAIL fresh_m_rdata got %h exp a5a50001", m_rdata); end
        tick();
        m_valid = 1'b0;
        s_ready = 4'b0000;
        #1;
        vec_cnt++; if (m_ready !== 1'b0) begin miscmp++; $display("FAIL fresh_done_m_ready got %b exp 0", m_ready); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit exceeded got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_decode_miss();
        test_timeout();
        test_err_saturation();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
